// File: rtl/tinyfpga_pkg.sv
// tinyfpga_pkg: shared types, CRC constants and sizing helper for the bitstream loader.
// Contents: state_t loader FSM states, CRC8_POLY / CRC8_INIT, chain_bytes(chain_len).
package tinyfpga_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT, CRC_WAIT, CRC_CHK, DONE} state_t;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    function automatic int chain_bytes(input int chain_len);
        return (chain_len + 7) / 8;
    endfunction
endpackage

// File: rtl/bitstream_crc8.sv
// bitstream_crc8: byte-wide CRC-8 (MSB first) accumulator register.
// Ports: clk, rst (sync active-high), clr (reload init), en (fold in data), data[7:0], crc[7:0].
module bitstream_crc8
    import tinyfpga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);
    logic [7:0] nxt;
    always_comb begin
        nxt = crc ^ data;
        for (int i = 0; i < 8; i++)
            nxt = nxt[7] ? ({nxt[6:0], 1'b0} ^ CRC8_POLY) : {nxt[6:0], 1'b0};
    end
    always_ff @(posedge clk)
        if (rst || clr)
            crc <= CRC8_INIT;
        else if (en)
            crc <= nxt;
endmodule

// File: rtl/bitstream_loader.sv
// bitstream_loader: byte-stream to bit-serial feeder for the configuration chain.
// Ports: clk, rst (sync active-high), start, in_data/in_valid/in_ready (byte handshake),
//        prog_clk/prog_en/prog_in (chain drive, registered), busy, done (pulse), error (sticky CRC).
// Optional feature: define BITSTREAM_LOADER_CRC_EN to consume and check a CRC-8 trailer byte.
module bitstream_loader
    import tinyfpga_pkg::*;
#(
    parameter int CHAIN_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       prog_clk,
    output logic       prog_en,
    output logic       prog_in,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int NBYTES    = chain_bytes(CHAIN_LEN);
    localparam int LAST_BITS = CHAIN_LEN - 8 * (NBYTES - 1);
    localparam int BW        = $clog2(NBYTES + 1);

    state_t          state, state_n;
    logic            phase;
    logic [2:0]      bit_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [7:0]      sr;
    logic            accept, last_byte, last_bit, go;

    assign in_ready  = state == WAIT_BYTE || state == CRC_WAIT;
    assign accept    = in_valid && in_ready;
    assign go        = state == IDLE && start;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign last_byte = byte_cnt == BW'(NBYTES - 1);
    // the final byte may be partial; its low pad bits are never shifted out
    assign last_bit  = bit_cnt == (last_byte ? 3'(LAST_BITS - 1) : 3'd7);

    always_ff @(posedge clk)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? WAIT_BYTE : IDLE;
            WAIT_BYTE: state_n = accept ? SHIFT : WAIT_BYTE;
            SHIFT:
                if (phase && last_bit)
`ifdef BITSTREAM_LOADER_CRC_EN
                    state_n = last_byte ? CRC_WAIT : WAIT_BYTE;
            CRC_WAIT:  state_n = accept ? CRC_CHK : CRC_WAIT;
            CRC_CHK:   state_n = DONE;
`else
                    state_n = last_byte ? DONE : WAIT_BYTE;
`endif
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) begin
            phase    <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sr       <= '0;
            prog_clk <= 1'b0;
            prog_en  <= 1'b0;
            prog_in  <= 1'b0;
        end else begin
            prog_en  <= state_n == WAIT_BYTE || state_n == SHIFT || state_n == CRC_WAIT;
            // rising chain clock on the second cycle of every bit
            prog_clk <= state == SHIFT && !phase;
            if (go) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end
            if (accept)
                sr <= in_data;
            // first bit goes out with the accept so it is stable a full cycle before the rise
            if (accept && state == WAIT_BYTE)
                prog_in <= in_data[7];
            if (state == SHIFT) begin
                phase <= !phase;
                if (phase) begin
                    if (last_bit) begin
                        bit_cnt  <= '0;
                        byte_cnt <= byte_cnt + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        sr      <= {sr[6:0], 1'b0};
                        prog_in <= sr[6];
                    end
                end
            end
        end

`ifdef BITSTREAM_LOADER_CRC_EN
    logic [7:0] crc;
    bitstream_crc8 u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (go),
        .en   (accept && state == WAIT_BYTE),
        .data (in_data),
        .crc  (crc)
    );
    // the trailer byte lands in sr during CRC_WAIT
    always_ff @(posedge clk)
        if (rst || go)
            error <= 1'b0;
        else if (state == CRC_CHK)
            error <= error | (sr != crc);
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_bitstream_loader.sv
// tb_bitstream_loader: self-checking bench for bitstream_loader (CHAIN_LEN 12 and 64 instances).
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed %0h, expected %0h", tag, (obs), (exp)); end end
module tb_bitstream_loader;
`ifdef BITSTREAM_LOADER_CRC_EN
    localparam bit CRC = 1'b1;
`else
    localparam bit CRC = 1'b0;
`endif
    localparam int L0 = 12, N0 = 2, L1 = 64, N1 = 8;

    logic clk = 1'b0;
    logic rst;
    logic start[2], valid[2], ready[2], pclk[2], pen[2], pin[2], busy[2], done[2], err[2];
    logic [7:0] data[2];
    always #5 clk = ~clk;

    bitstream_loader #(.CHAIN_LEN(L0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .in_data(data[0]), .in_valid(valid[0]),
        .in_ready(ready[0]), .prog_clk(pclk[0]), .prog_en(pen[0]), .prog_in(pin[0]),
        .busy(busy[0]), .done(done[0]), .error(err[0]));
    bitstream_loader #(.CHAIN_LEN(L1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_data(data[1]), .in_valid(valid[1]),
        .in_ready(ready[1]), .prog_clk(pclk[1]), .prog_en(pen[1]), .prog_in(pin[1]),
        .busy(busy[1]), .done(done[1]), .error(err[1]));

    int errors = 0, checks = 0;
    bit got[2][$];
    int rises[2], dones[2], viol[2];
    logic ppclk[2], ppin[2], ppen[2];
    logic [7:0] pay[$];

    always @(negedge clk)
        for (int d = 0; d < 2; d++) begin
            if (pclk[d] === 1'b1 && ppclk[d] !== 1'b1) begin
                got[d].push_back(pin[d]);
                rises[d]++;
                if (ppin[d] !== pin[d] || ppen[d] !== 1'b1 || pen[d] !== 1'b1) viol[d]++;
            end
            if (pclk[d] === 1'b1 && ready[d] === 1'b1) viol[d]++;
            if (done[d] === 1'b1) dones[d]++;
            ppclk[d] = pclk[d];
            ppin[d]  = pin[d];
            ppen[d]  = pen[d];
        end

    function automatic logic [7:0] crc_ref(input int n);
        bit m[$];
        logic [8:0] p = 9'h107;
        logic [7:0] r;
        for (int i = 0; i < n; i++)
            for (int b = 7; b >= 0; b--) m.push_back(pay[i][b]);
        repeat (8) m.push_back(1'b0);
        for (int i = 0; i < 8 * n; i++)
            if (m[i]) for (int j = 0; j < 9; j++) m[i+j] ^= p[8-j];
        for (int j = 0; j < 8; j++) r[7-j] = m[8*n+j];
        return r;
    endfunction

    function automatic logic [63:0] exp_bits(input int len);
        logic [63:0] v = '0;
        for (int i = 0; i < len; i++) v[i] = pay[i/8][7-(i%8)];
        return v;
    endfunction

    function automatic logic [63:0] obs_bits(input int d);
        logic [63:0] v = '0;
        for (int i = 0; i < got[d].size() && i < 64; i++) v[i] = got[d][i];
        return v;
    endfunction

    task automatic load(input int d, input bit rnd, input bit poke, input bit abort,
                        output int dur, output logic e, output int lat);
        int idx = 0, acc_t = -1, rise_t = -1;
        bit fin = 0;
        got[d].delete();
        rises[d] = 0;
        dones[d] = 0;
        dur = -1;
        e = 1'bx;
        @(negedge clk);
        start[d] = 1'b1;
        valid[d] = 1'b0;
        for (int t = 1; t < 6000 && !fin; t++) begin
            @(negedge clk);
            start[d] = poke && t == 25;
            if (done[d] === 1'b1) begin
                dur = t;
                e = err[d];
                fin = 1;
                valid[d] = 1'b0;
            end else if (abort && idx == 3 && pclk[d] === 1'b1) begin
                rst = 1'b1;
                valid[d] = 1'b0;
                fin = 1;
            end else begin
                valid[d] = idx < pay.size() && (!rnd || $urandom_range(1, 0) == 1);
                data[d] = idx < pay.size() ? pay[idx] : 8'h00;
                #1;
                if (valid[d] && ready[d] === 1'b1) begin
                    if (acc_t < 0) acc_t = t;
                    idx++;
                end
                if (pclk[d] === 1'b1 && rise_t < 0) rise_t = t;
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $error("FAIL timeout: dut%0d load did not finish within 6000 cycles", d);
        end
        start[d] = 1'b0;
        valid[d] = 1'b0;
        lat = rise_t - acc_t;
        @(negedge clk);
    endtask

    initial begin
        int dur, lat;
        logic e;
        logic [7:0] good;
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; valid[d] = 0; data[d] = 0;
            ppclk[d] = 0; ppin[d] = 0; ppen[d] = 0;
            rises[d] = 0; dones[d] = 0; viol[d] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            `CHK("rst_in_ready", ready[d], 1'b0)
            `CHK("rst_prog_clk", pclk[d], 1'b0)
            `CHK("rst_prog_en", pen[d], 1'b0)
            `CHK("rst_prog_in", pin[d], 1'b0)
            `CHK("rst_busy", busy[d], 1'b0)
            `CHK("rst_done", done[d], 1'b0)
            `CHK("rst_error", err[d], 1'b0)
        end
        rst = 1'b0;

        pay = '{8'hA5, 8'h30};
        good = crc_ref(N0);
        if (CRC) pay.push_back(good);
        load(0, 0, 0, 0, dur, e, lat);
        `CHK("basic_bits", obs_bits(0), exp_bits(L0))
        `CHK("basic_rises", rises[0], L0)
        `CHK("basic_cycles", dur, 1 + N0 + 2 * L0 + (CRC ? 2 : 0))
        `CHK("basic_latency", lat, 2)
        `CHK("basic_done_once", dones[0], 1)
        `CHK("basic_busy_after", busy[0], 1'b0)
        `CHK("basic_error", e, 1'b0)

        if (CRC) begin
            pay[N0] = good ^ 8'h01;
            load(0, 0, 0, 0, dur, e, lat);
            `CHK("badcrc_done_once", dones[0], 1)
            `CHK("badcrc_error", e, 1'b1)
            `CHK("badcrc_error_held", err[0], 1'b1)
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
            `CHK("start_clears_error", err[0], 1'b0)
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end

        pay.delete();
        for (int i = 0; i < N1; i++) pay.push_back(8'($urandom));
        if (CRC) pay.push_back(crc_ref(N1));
        load(1, 1, 0, 0, dur, e, lat);
        `CHK("bp_bits", obs_bits(1), exp_bits(L1))
        `CHK("bp_rises", rises[1], L1)
        `CHK("bp_done_once", dones[1], 1)
        `CHK("bp_error", e, 1'b0)

        load(1, 0, 0, 1, dur, e, lat);
        rst = 1'b0;
        `CHK("abort_prog_en", pen[1], 1'b0)
        `CHK("abort_prog_clk", pclk[1], 1'b0)
        `CHK("abort_busy", busy[1], 1'b0)
        `CHK("abort_in_ready", ready[1], 1'b0)
        `CHK("abort_done", done[1], 1'b0)
        load(1, 0, 0, 0, dur, e, lat);
        `CHK("reload_bits", obs_bits(1), exp_bits(L1))
        `CHK("reload_rises", rises[1], L1)
        `CHK("reload_cycles", dur, 1 + N1 + 2 * L1 + (CRC ? 2 : 0))

        pay.delete();
        for (int i = 0; i < N0; i++) pay.push_back(8'($urandom));
        if (CRC) pay.push_back(crc_ref(N0));
        load(0, 0, 1, 0, dur, e, lat);
        `CHK("poke_bits", obs_bits(0), exp_bits(L0))
        `CHK("poke_rises", rises[0], L0)
        `CHK("poke_cycles", dur, 1 + N0 + 2 * L0 + (CRC ? 2 : 0))
        `CHK("poke_done_once", dones[0], 1)

        `CHK("protocol_dut0", viol[0], 0)
        `CHK("protocol_dut1", viol[1], 0)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
